// File: rtl/axi_msg_pkg.sv
// -----------------------------------------------------------------------------
// axi_msg_pkg
//   Shared definitions for the axi_msg_master slice: message width, stall
//   timer width and the handshake FSM state type.
//   No ports (package).
// -----------------------------------------------------------------------------
package axi_msg_pkg;

    localparam int unsigned MSG_W   = 32;
    localparam int unsigned TIMER_W = 16;

    // IDLE: output register empty (valid low); SEND: output register holds a message
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/axi_msg_master_if.sv
// -----------------------------------------------------------------------------
// axi_msg_master_if
//   Valid/ready message handshake between axi_msg_master and axi_slave.
//   Signals:
//     valid    master -> slave   message is valid
//     ready    slave  -> master  slave accepts the message this cycle
//     message  master -> slave   MSG_W-bit payload
//   Modports: master (drives valid/message), slave (drives ready).
// -----------------------------------------------------------------------------
interface axi_msg_master_if;
    import axi_msg_pkg::*;

    logic             valid;
    logic             ready;
    logic [MSG_W-1:0] message;

    modport master (output valid, output message, input ready);
    modport slave  (input valid, input message, output ready);

endinterface

// File: rtl/msg_fifo_mem.sv
// -----------------------------------------------------------------------------
// msg_fifo_mem
//   DEPTH x MSG_W register array backing the message FIFO. One synchronous
//   write port, one asynchronous read port (used to present the FIFO head).
//   Ports:
//     clk      in   clock
//     wr_en    in   write wr_data at wr_addr on the rising edge
//     wr_addr  in   write address
//     wr_data  in   write data
//     rd_addr  in   read address
//     rd_data  out  mem[rd_addr], combinational
//   Storage is not reset; validity is tracked by the owner's pointers/count.
// -----------------------------------------------------------------------------
module msg_fifo_mem
    import axi_msg_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [MSG_W-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [MSG_W-1:0]         rd_data
);

    logic [MSG_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi_msg_master.sv
// -----------------------------------------------------------------------------
// axi_msg_master
//   Buffers 32-bit messages written by the core and presents them one at a
//   time on a valid/ready handshake. DEPTH-entry FIFO plus one output holding
//   register; a two-state FSM (IDLE/SEND) owns the handshake.
//   Ports:
//     clk_i       in   clock, all logic on posedge
//     reset_ni    in   asynchronous active-low reset
//     wr_en_i     in   push wr_data_i this cycle
//     wr_data_i   in   message to send
//     clear_i     in   synchronous flush of FIFO, output register and sticky flags
//     full_o      out  FIFO holds DEPTH entries
//     empty_o     out  FIFO empty and output register empty
//     level_o     out  FIFO occupancy 0..DEPTH (output register excluded)
//     overflow_o  out  sticky: a push was dropped
//     bus         master modport: valid / ready / message
//     timeout_o   out  sticky stall flag
//   Configuration macro: AXI_MST_TIMEOUT_EN enables the stall timer behind
//   timeout_o; without it timeout_o is tied low and TIMEOUT_CYC is unused.
// -----------------------------------------------------------------------------
module axi_msg_master
    import axi_msg_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   wr_en_i,
    input  logic [MSG_W-1:0]       wr_data_i,
    input  logic                   clear_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o,
    axi_msg_master_if.master       bus,
    output logic                   timeout_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [MSG_W-1:0] out_q;
    logic [MSG_W-1:0] head;
    logic             overflow_q;

    logic fifo_empty;
    logic fifo_full;
    logic xfer;
    logic pop;          // FIFO head moves into the output register
    logic load_direct;  // wr_data_i goes straight into the output register
    logic push_req;     // a write that targets the FIFO
    logic push_ok;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign xfer       = (state_q == SEND) && bus.ready;

    // ------------------------------------------------------------------
    // FSM next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        load_direct = 1'b0;
        push_req    = wr_en_i;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end else if (wr_en_i) begin
                    // Bypass only when the FIFO is empty, so ordering holds
                    load_direct = 1'b1;
                    push_req    = 1'b0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything; a coinciding write is discarded silently
        if (clear_i) begin
            state_d     = IDLE;
            pop         = 1'b0;
            load_direct = 1'b0;
            push_req    = 1'b0;
        end
    end

    // Fullness is judged on the pre-cycle count: a same-cycle pop frees nothing
    assign push_ok = push_req && !fifo_full;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, count, output register, overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);

            if (pop) begin
                out_q <= head;
            end else if (load_direct) begin
                out_q <= wr_data_i;
            end

            if (push_req && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    msg_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk_i),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data_i),
        .rd_addr (rd_ptr_q),
        .rd_data (head)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.valid   = (state_q == SEND);
    assign bus.message = (state_q == SEND) ? out_q : '0;
    assign full_o      = fifo_full;
    assign empty_o     = fifo_empty && (state_q == IDLE);
    assign level_o     = count_q;
    assign overflow_o  = overflow_q;

`ifdef AXI_MST_TIMEOUT_EN
    // stall_q counts completed stall cycles; the flag sets on the cycle
    // that brings the total to TIMEOUT_CYC.
    localparam logic [TIMER_W-1:0] STALL_LIM = TIMER_W'(TIMEOUT_CYC - 1);

    logic [TIMER_W-1:0] stall_q;
    logic               timeout_q;
    logic               stall;

    assign stall = (state_q == SEND) && !bus.ready;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else if (clear_i) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else if (stall) begin
            if (stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
            if (stall_q >= STALL_LIM) begin
                timeout_q <= 1'b1;
            end
        end else begin
            stall_q <= '0;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_o          = 1'b0;
`endif

endmodule
